// File: rtl/des_key_sched.sv
`default_nettype none
// ==== des_key_sched : DES round-subkey generator, K1..K16 (encrypt) or K16..K1 (decrypt) ====
// ==== rev 1.0                                                                             ====
module des_key_sched #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_load,
  input  logic [64:1] key_in,
  input  logic        dir,
  output logic        busy,
  output logic [48:1] subkey,
  output logic [3:0]  subkey_idx,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        done
);

  localparam int PC1 [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [1:48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic        dir_q;
  logic [1:28] c, d;
  logic [1:28] pc1_c, pc1_d;
  logic [1:56] cd;
  logic        adv_single;
  logic        last;
  logic        unused_parity;

  if (NUM_ROUNDS != 16) begin : g_bad_rounds
    $error("des_key_sched: NUM_ROUNDS must be 16");
  end

  for (genvar i = 1; i <= 28; i++) begin : g_pc1
    assign pc1_c[i] = key_in[PC1[i]];
    assign pc1_d[i] = key_in[PC1[i+28]];
  end

  assign cd = {c, d};
  for (genvar i = 1; i <= 48; i++) begin : g_pc2
    assign subkey[i] = cd[PC2[i]];
  end

  assign unused_parity = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                           key_in[40], key_in[48], key_in[56], key_in[64]};

  // Rounds 1, 2, 9 and 16 (idx 0, 1, 8, 15) shift by one; all others by two.
  function automatic logic one_shift(input logic [3:0] i);
    return (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
  endfunction

  function automatic logic [1:28] rot(input logic [1:28] x, input logic right,
                                      input logic single);
    if (!right) return single ? {x[2:28], x[1]} : {x[3:28], x[1:2]};
    else        return single ? {x[28], x[1:27]} : {x[27:28], x[1:26]};
  endfunction

  // Encrypt moves to round idx+2 (shift of that round); decrypt undoes round idx+1.
  assign adv_single = dir_q ? one_shift(subkey_idx) : one_shift(subkey_idx + 4'd1);
  assign last       = dir_q ? (subkey_idx == 4'd0) : (subkey_idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dir_q        <= 1'b0;
      c            <= '0;
      d            <= '0;
      subkey_idx   <= 4'd0;
      busy         <= 1'b0;
      subkey_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (key_load) begin
            dir_q        <= dir;
            busy         <= 1'b1;
            subkey_valid <= 1'b1;
            state        <= RUN;
            if (dir) begin
              // C16D16 equals C0D0, so decryption starts from the raw PC-1 output.
              c          <= pc1_c;
              d          <= pc1_d;
              subkey_idx <= LAST;
            end else begin
              c          <= rot(pc1_c, 1'b0, 1'b1);
              d          <= rot(pc1_d, 1'b0, 1'b1);
              subkey_idx <= 4'd0;
            end
          end
        end
        RUN: begin
          if (subkey_ready) begin
            if (last) begin
              state        <= DONE;
              busy         <= 1'b0;
              subkey_valid <= 1'b0;
              done         <= 1'b1;
            end else begin
              c          <= rot(c, dir_q, adv_single);
              d          <= rot(d, dir_q, adv_single);
              subkey_idx <= dir_q ? subkey_idx - 4'd1 : subkey_idx + 4'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched.sv
`default_nettype none
// ==== tb_des_key_sched : self-checking bench for des_key_sched (rev 1.0) ====
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_load;
  logic [64:1] key_in;
  logic        dir;
  logic        busy;
  logic [48:1] subkey;
  logic [3:0]  subkey_idx;
  logic        subkey_valid;
  logic        subkey_ready;
  logic        done;

  des_key_sched #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in), .dir(dir),
    .busy(busy), .subkey(subkey), .subkey_idx(subkey_idx),
    .subkey_valid(subkey_valid), .subkey_ready(subkey_ready), .done(done)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  logic [47:0] cap_sub [16];
  logic [3:0]  cap_idx [16];
  int          ncap, nvalid, ncyc;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Hex notation puts DES bit 1 at the MSB; the ports index DES bit i at [i].
  function automatic logic [64:1] to_key(input logic [63:0] h);
    logic [64:1] k;
    for (int i = 1; i <= 64; i++) k[i] = h[64-i];
    return k;
  endfunction

  function automatic logic [47:0] to_hex(input logic [48:1] s);
    logic [47:0] h;
    for (int i = 1; i <= 48; i++) h[48-i] = s[i];
    return h;
  endfunction

  // Reference subkey Kr: PC-1 halves rotated left by the cumulative shift total, then PC-2.
  function automatic logic [47:0] model_sub(input logic [63:0] kh, input int r);
    int   total;
    logic c0 [28];
    logic d0 [28];
    logic cd [56];
    logic [47:0] res;
    total = 0;
    for (int j = 1; j <= r; j++) total += (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
    for (int i = 0; i < 28; i++) begin
      c0[i] = kh[64 - pc1_t[i]];
      d0[i] = kh[64 - pc1_t[28+i]];
    end
    for (int i = 0; i < 28; i++) begin
      cd[i]    = c0[(i + total) % 28];
      cd[28+i] = d0[(i + total) % 28];
    end
    for (int i = 0; i < 48; i++) res[47-i] = cd[pc2_t[i]-1];
    return res;
  endfunction

  task automatic start(input logic [63:0] kh, input logic dr);
    key_load = 1'b1;
    key_in   = to_key(kh);
    dir      = dr;
    @(posedge clk); #1;
    key_load = 1'b0;
    key_in   = {$urandom, $urandom};
    dir      = 1'($urandom);
  endtask

  // Entered one cycle after the load edge; runs until the done pulse and one cycle beyond.
  task automatic collect(input int pct, input int stall_at, input bit load_busy,
                         input logic [63:0] alt_key);
    int          stall_cnt;
    bit          prev_hold, fin, loaded;
    logic [47:0] prev_sub;
    logic [3:0]  prev_idx;
    ncap = 0; nvalid = 0; ncyc = 0;
    stall_cnt = 0; prev_hold = 0; fin = 0; loaded = 0;
    prev_sub = '0; prev_idx = '0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      ncyc++;
      if (done) begin
        fin = 1;
        check("busy_in_done", 64'(busy), 64'd0);
        check("valid_in_done", 64'(subkey_valid), 64'd0);
        if (load_busy) begin
          key_load = 1'b1;
          key_in   = to_key(alt_key);
          dir      = 1'($urandom);
        end
      end else begin
        if (prev_hold) begin
          check("hold_valid", 64'(subkey_valid), 64'd1);
          check("hold_sub", 64'(to_hex(subkey)), 64'(prev_sub));
          check("hold_idx", 64'(subkey_idx), 64'(prev_idx));
        end
        if (subkey_valid) begin
          nvalid++;
          if (stall_at == int'(subkey_idx) && stall_cnt < 20) begin
            subkey_ready = 1'b0;
            stall_cnt++;
          end else begin
            subkey_ready = ($urandom_range(0, 99) < pct);
          end
          if (subkey_ready) begin
            if (ncap < 16) begin
              cap_sub[ncap] = to_hex(subkey);
              cap_idx[ncap] = subkey_idx;
            end
            ncap++;
          end
          prev_hold = !subkey_ready;
          prev_sub  = to_hex(subkey);
          prev_idx  = subkey_idx;
          if (load_busy && !loaded && subkey_idx == 4'd4) begin
            key_load = 1'b1;
            key_in   = to_key(alt_key);
            dir      = 1'($urandom);
            loaded   = 1;
          end
        end else begin
          prev_hold = 0;
        end
      end
      @(posedge clk); #1;
      key_load = 1'b0;
    end
    subkey_ready = 1'b1;
    if (!fin) check("done_timeout", 64'd0, 64'd1);
    else      check("done_pulse_width", 64'(done), 64'd0);
  endtask

  task automatic check_run(input logic [63:0] kh, input logic dr);
    check("num_transfers", 64'(ncap), 64'd16);
    for (int n = 0; n < 16 && n < ncap; n++) begin
      check("seq_sub", 64'(cap_sub[n]), 64'(model_sub(kh, dr ? 16 - n : n + 1)));
      check("seq_idx", 64'(cap_idx[n]), dr ? 64'(15 - n) : 64'(n));
    end
  endtask

  typedef struct {
    logic [63:0] key;
    logic        dr;
    int          pos;
    logic [3:0]  idx;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [9];
  logic [47:0] enc_a [16];

  initial begin
    vecs[0] = '{KEY_A, 1'b0,  0, 4'd0,  48'h1B02EFFC7072};
    vecs[1] = '{KEY_A, 1'b0,  1, 4'd1,  48'h79AED9DBC9E5};
    vecs[2] = '{KEY_A, 1'b0, 15, 4'd15, 48'hCB3D8B0E17F5};
    vecs[3] = '{KEY_A, 1'b1,  0, 4'd15, 48'hCB3D8B0E17F5};
    vecs[4] = '{KEY_A, 1'b1, 14, 4'd1,  48'h79AED9DBC9E5};
    vecs[5] = '{KEY_A, 1'b1, 15, 4'd0,  48'h1B02EFFC7072};
    vecs[6] = '{KEY_P, 1'b0,  0, 4'd0,  48'h1B02EFFC7072};
    vecs[7] = '{KEY_P, 1'b0,  1, 4'd1,  48'h79AED9DBC9E5};
    vecs[8] = '{KEY_P, 1'b0, 15, 4'd15, 48'hCB3D8B0E17F5};

    rst_n = 1'b0; key_load = 1'b0; key_in = '0; dir = 1'b0; subkey_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    check("rst_idx", 64'(subkey_idx), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer vectors, full throughput.
    for (int v = 0; v < 9; v++) begin
      start(vecs[v].key, vecs[v].dr);
      check("first_valid", 64'(subkey_valid), 64'd1);
      check("first_busy", 64'(busy), 64'd1);
      collect(100, -1, 0, '0);
      check("vec_sub", 64'(cap_sub[vecs[v].pos]), 64'(vecs[v].exp));
      check("vec_idx", 64'(cap_idx[vecs[v].pos]), 64'(vecs[v].idx));
      check("valid_cycles", 64'(nvalid), 64'd16);
      check("done_cycle", 64'(ncyc), 64'd17);
    end

    // Decrypt is the exact reverse of encrypt.
    start(KEY_A, 1'b0);
    collect(100, -1, 0, '0);
    for (int n = 0; n < 16; n++) enc_a[n] = cap_sub[n];
    start(KEY_A, 1'b1);
    collect(100, -1, 0, '0);
    for (int n = 0; n < 16; n++) check("dec_reverse", 64'(cap_sub[n]), 64'(enc_a[15-n]));

    // Backpressure with a 20-cycle stall at idx 7.
    start(KEY_A, 1'b0);
    collect(30, 7, 0, '0);
    check_run(KEY_A, 1'b0);
    for (int n = 0; n < 16; n++) check("bp_vs_full", 64'(cap_sub[n]), 64'(enc_a[n]));

    // key_load while busy (idx 4) and in the DONE cycle.
    start(KEY_A, 1'b0);
    collect(100, -1, 1, KEY_B);
    check_run(KEY_A, 1'b0);
    check("idle_after_done_load_valid", 64'(subkey_valid), 64'd0);
    check("idle_after_done_load_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("still_idle", 64'(subkey_valid), 64'd0);

    // Reset mid-run at idx 9, then a decrypt reload.
    start(KEY_A, 1'b0);
    for (int k = 0; k < 40 && !(subkey_valid && subkey_idx == 4'd9); k++) begin
      @(posedge clk); #1;
    end
    check("reached_idx9", 64'(subkey_idx), 64'd9);
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(subkey_valid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_idx", 64'(subkey_idx), 64'd0);
    check("async_subkey", 64'(subkey), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    start(KEY_A, 1'b1);
    check("reload_idx", 64'(subkey_idx), 64'd15);
    check("reload_k16", 64'(to_hex(subkey)), 64'h0000CB3D8B0E17F5);
    collect(100, -1, 0, '0);
    check_run(KEY_A, 1'b1);

    // Random keys, directions and ready duty against the model.
    for (int t = 0; t < 8; t++) begin
      logic [63:0] kr;
      logic        dr;
      kr = {$urandom, $urandom};
      dr = 1'($urandom);
      start(kr, dr);
      collect((t < 4) ? 30 : 70, (t == 0) ? 7 : -1, 0, '0);
      check_run(kr, dr);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
- Sequential DES key schedule; the companion to the round datapath (E expansion, S-box, P).
- Accepts one 64-bit key and streams the 16 48-bit round subkeys over a valid/ready handshake, one per cycle at full throughput.
- In encrypt mode subkeys are emitted K1..K16 using left rotations. In decrypt mode they are emitted K16..K1 using right rotations, so the shared Feistel round logic runs decryption unchanged.

Parameters:
- NUM_ROUNDS, 16, number of subkeys emitted per key. Fixed at 16 for DES; present only for bench shortening and asserted equal to 16 in synthesis.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- key_load  input  1  request to start a schedule with key_in/dir
- key_in  input  [64:1]  DES key. Index i = DES bit i (bit 1 = leftmost). Parity bits 8,16,..,64 are ignored.
- dir  input  1  0 = encrypt order (K1 first), 1 = decrypt order (K16 first)
- busy  output  1  schedule in progress; key_load is ignored while high
- subkey  output  [48:1]  current subkey. Index i = DES PC-2 output bit i.
- subkey_idx  output  4  round number minus 1 of the presented subkey (0 = K1 .. 15 = K16)
- subkey_valid  output  1  subkey/subkey_idx valid
- subkey_ready  input  1  consumer accepts the subkey when valid && ready
- done  output  1  one-cycle pulse after the last subkey is accepted

Behaviour:
- Reset (rst_n low, asynchronous): busy=0, subkey_valid=0, done=0, subkey=0, subkey_idx=0, C/D registers=0, step counter=0, FSM=IDLE.
- Tables: PC-1 (64->56, split into C[1:28], D[1:28]) and PC-2 (56->48) are the FIPS 46-3 tables, with direct 1-based bit indexing. Shift schedule s[r], r=1..16 = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- FSM states: IDLE, RUN, DONE.
- IDLE, key_load=1 at edge T:
  - latch dir;
  - encrypt: C/D <= rotl(PC-1(key_in), s[1]), step=1;
  - decrypt: C/D <= PC-1(key_in), since C16D16 = C0D0; step=16;
  - go to RUN.
- Cycle T+1: busy=1, subkey_valid=1, subkey=PC-2(C,D) (combinational from C/D, or registered in parallel; either way it is valid in the same cycle as subkey_valid), subkey_idx=step-1.
- RUN, valid&&ready at an edge, not the last subkey:
  - encrypt: step<=step+1, C/D <= rotl(C/D, s[step+1]);
  - decrypt: C/D <= rotr(C/D, s[step]), step<=step-1;
  - subkey_valid stays 1, so back-to-back accepts give one subkey per cycle.
- RUN, valid&&ready on the last subkey (step 16 in encrypt, step 1 in decrypt): go to DONE.
- DONE (one cycle): subkey_valid=0, busy=0, done=1, then IDLE. A key_load in the DONE cycle is ignored; key_load is sampled only in IDLE.
- Stall: while valid && !ready, subkey, subkey_idx and C/D hold stable. No limit on stall length.
- Rotation: rotl/rotr are 28-bit circular rotations applied independently to C and D (rotl by 2 = two 1-bit rotations).
- key_load while busy: ignored, and the latched key/dir are unaffected. key_in/dir are don't-care outside the load cycle.
- Reset asserted mid-schedule: outputs return to reset values immediately. The first key_load after rst_n rises starts a fresh schedule.
- Latency: key_load to first subkey_valid = 1 cycle. Key load to done pulse = 17 cycles minimum with ready held high.

Test Plan:
- Encrypt vectors. Stimulus: key 0x133457799BBCDFF1 (MSB = DES bit 1), dir=0, ready=1. Required: idx0 = 0x1B02EFFC7072, idx1 = 0x79AED9DBC9E5, idx15 = 0xCB3D8B0E17F5 (hex MSB = subkey bit 1); exactly 16 valid cycles; done on cycle 17 after load.
- Decrypt vectors. Stimulus: same key, dir=1. Required: first subkey 0xCB3D8B0E17F5 with idx=15, then 0x79AED9DBC9E5 at idx=1 as the 15th transfer, last 0x1B02EFFC7072 at idx=0; the full sequence is the exact reverse of the encrypt run.
- Backpressure. Stimulus: random ready (about 30% duty), including a 20-cycle stall at idx=7. Required: subkey and idx stable throughout the stall; no subkey dropped or duplicated; same 16 values as the ready=1 run.
- Load while busy. Stimulus: key_load with a different key at idx=4, and again in the DONE cycle. Required: both ignored; the sequence matches the original key; busy returns to 0 after done.
- Reset mid-run. Stimulus: rst_n pulsed low at idx=9, then reload with dir=1. Required: valid/busy drop asynchronously; the new run starts cleanly at idx=15 with the correct K16.
- Parity independence. Stimulus: key 0x133457799BBCDFF1 with all parity bits (8,16,..,64) inverted. Required: subkeys identical to the encrypt-vectors scenario.
